// File: rtl/delay_pkg.sv
// delay_pkg: shared types and default sizing for the circular-buffer delay line.
//   DELAY_ADD_WIDTH : default RAM address width (buffer depth 2**DELAY_ADD_WIDTH)
//   delay_state_t   : controller state encoding
package delay_pkg;

    localparam int DELAY_ADD_WIDTH = 9;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN
    } delay_state_t;

endpackage

// File: rtl/delay_ctrl_if.sv
// delay_ctrl_if: sample strobe/offset inputs and RAM strobe/address outputs of the delay controller.
//   en, offset                    : sample strobe and requested delay (0 = full depth)
//   wr, rd, wr_addr, rd_addr      : dual-port RAM write/read enables and addresses
//   delayed_valid, filling        : RAM read data qualifier and history-accumulation flag
interface delay_ctrl_if #(
    parameter int ADD_WIDTH = delay_pkg::DELAY_ADD_WIDTH
);

    logic                 en;
    logic [ADD_WIDTH-1:0] offset;
    logic                 wr;
    logic                 rd;
    logic [ADD_WIDTH-1:0] wr_addr;
    logic [ADD_WIDTH-1:0] rd_addr;
    logic                 delayed_valid;
    logic                 filling;

    modport master (
        input  en, offset,
        output wr, rd, wr_addr, rd_addr, delayed_valid, filling
    );

    modport slave (
        output en, offset,
        input  wr, rd, wr_addr, rd_addr, delayed_valid, filling
    );

endinterface

// File: rtl/delay_ctrl.sv
// delay_ctrl: drives a dual-port sample RAM as a circular delay line of programmable length.
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : delay_ctrl_if master (en/offset in; wr/rd/addresses/delayed_valid/filling out)
module delay_ctrl
    import delay_pkg::*;
#(
    parameter int ADD_WIDTH = DELAY_ADD_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    delay_ctrl_if.master bus
);

    localparam logic [ADD_WIDTH:0] FULL = {1'b1, {ADD_WIDTH{1'b0}}};

    delay_state_t         state_q, state_d;
    logic [ADD_WIDTH-1:0] wp_q, wp_d;
    logic [ADD_WIDTH-1:0] off_q, off_d;
    logic [ADD_WIDTH:0]   fill_cnt_q, fill_cnt_d;
    logic                 delayed_valid_q, delayed_valid_d;
    logic [ADD_WIDTH:0]   need;
    logic                 wr, rd;

    always_comb begin
        state_d    = state_q;
        wp_d       = wp_q;
        off_d      = off_q;
        fill_cnt_d = fill_cnt_q;
        wr         = 1'b0;
        rd         = 1'b0;
        // offset 0 selects the whole buffer
        need       = (off_q == '0) ? FULL : {1'b0, off_q};
        if (bus.en) begin
            if (state_q == IDLE) begin
                // first strobe only arms the controller; nothing is written
                off_d   = bus.offset;
                state_d = FILL;
            end else if (bus.offset != off_q) begin
                // new delay: history is stale, so this strobe restarts the fill
                wr         = 1'b1;
                wp_d       = wp_q + 1'b1;
                off_d      = bus.offset;
                fill_cnt_d = (ADD_WIDTH+1)'(1);
                state_d    = (bus.offset == ADD_WIDTH'(1)) ? RUN : FILL;
            end else if (state_q == FILL) begin
                wr         = 1'b1;
                wp_d       = wp_q + 1'b1;
                fill_cnt_d = fill_cnt_q + 1'b1;
                state_d    = (fill_cnt_d == need) ? RUN : FILL;
            end else begin
                wr   = 1'b1;
                rd   = 1'b1;
                wp_d = wp_q + 1'b1;
            end
        end
        delayed_valid_d = rd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            wp_q            <= '0;
            off_q           <= '0;
            fill_cnt_q      <= '0;
            delayed_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            wp_q            <= wp_d;
            off_q           <= off_d;
            fill_cnt_q      <= fill_cnt_d;
            delayed_valid_q <= delayed_valid_d;
        end
    end

    assign bus.wr            = wr;
    assign bus.rd            = rd;
    assign bus.wr_addr       = wp_q;
    // modular subtraction gives the wrap-around read pointer
    assign bus.rd_addr       = wp_q - off_q;
    assign bus.delayed_valid = delayed_valid_q;
    assign bus.filling       = (state_q == FILL);

endmodule

// File: tb/tb_delay_ctrl.sv
// tb_delay_ctrl: directed self-checking bench for delay_ctrl with a behavioural dual-port RAM.
module tb_delay_ctrl;
    import delay_pkg::*;

    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    delay_ctrl_if #(.ADD_WIDTH(AW)) bus();
    delay_ctrl #(.ADD_WIDTH(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [7:0] mem [16];
    logic [7:0] rdata;
    logic [7:0] din;
    always @(posedge clk) begin
        if (bus.rd) rdata <= mem[bus.rd_addr];
        if (bus.wr) mem[bus.wr_addr] <= din;
    end

    int pass_cnt = 0;
    int total = 0;
    int sample = 0;
    logic c_wr, c_rd, c_fill;
    logic [AW-1:0] c_wa, c_ra;

    // one clock of stimulus starting just after a falling edge; captures the
    // combinational outputs before the rising edge and returns after the next falling edge
    task automatic step(input logic e, input logic [AW-1:0] off);
        bus.en = e;
        bus.offset = off;
        din = 8'(sample);
        #1;
        c_wr = bus.wr;
        c_rd = bus.rd;
        c_wa = bus.wr_addr;
        c_ra = bus.rd_addr;
        c_fill = bus.filling;
        @(negedge clk);
        if (e) sample++;
        bus.en = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sample = 0;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (3) step(1'b0, 4'd0);
        total++; if (c_wr !== 1'b0) $display("FAIL reset_wr got %b want 0", c_wr); else pass_cnt++;
        total++; if (c_rd !== 1'b0) $display("FAIL reset_rd got %b want 0", c_rd); else pass_cnt++;
        total++; if (c_wa !== 4'd0) $display("FAIL reset_wr_addr got %0d want 0", c_wa); else pass_cnt++;
        total++; if (c_ra !== 4'd0) $display("FAIL reset_rd_addr got %0d want 0", c_ra); else pass_cnt++;
        total++; if (c_fill !== 1'b0) $display("FAIL reset_filling got %b want 0", c_fill); else pass_cnt++;
        total++; if (bus.delayed_valid !== 1'b0) $display("FAIL reset_dv got %b want 0", bus.delayed_valid); else pass_cnt++;
    endtask

    task automatic test_fill();
        step(1'b1, 4'd3);
        total++; if (c_wr !== 1'b0) $display("FAIL idle_absorb_wr got %b want 0", c_wr); else pass_cnt++;
        total++; if (bus.filling !== 1'b1) $display("FAIL fill_enter got %b want 1", bus.filling); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'd3);
            total++; if (c_wr !== 1'b1 || c_rd !== 1'b0) $display("FAIL fill_strobe[%0d] wr=%b rd=%b want wr=1 rd=0", i, c_wr, c_rd); else pass_cnt++;
            total++; if (c_wa !== 4'(i)) $display("FAIL fill_wr_addr[%0d] got %0d want %0d", i, c_wa, i); else pass_cnt++;
            total++; if (bus.delayed_valid !== 1'b0) $display("FAIL fill_dv[%0d] got %b want 0", i, bus.delayed_valid); else pass_cnt++;
        end
        total++; if (bus.filling !== 1'b0) $display("FAIL fill_exit got %b want 0", bus.filling); else pass_cnt++;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 4'd3);
            total++; if (c_wr !== 1'b1 || c_rd !== 1'b1) $display("FAIL run_strobe[%0d] wr=%b rd=%b want 1 1", k, c_wr, c_rd); else pass_cnt++;
            total++; if (c_wa !== 4'(k + 3) || c_ra !== 4'(k)) $display("FAIL run_addr[%0d] wa=%0d ra=%0d want %0d %0d", k, c_wa, c_ra, k + 3, k); else pass_cnt++;
            total++; if (bus.delayed_valid !== 1'b1) $display("FAIL run_dv[%0d] got %b want 1", k, bus.delayed_valid); else pass_cnt++;
            total++; if (rdata !== 8'(k + 1)) $display("FAIL run_data[%0d] got %0d want %0d", k, rdata, k + 1); else pass_cnt++;
        end
        step(1'b0, 4'd3);
        total++; if (bus.delayed_valid !== 1'b0) $display("FAIL dv_one_cycle got %b want 0", bus.delayed_valid); else pass_cnt++;
        total++; if (c_wr !== 1'b0 || c_rd !== 1'b0) $display("FAIL en_low_strobes wr=%b rd=%b want 0 0", c_wr, c_rd); else pass_cnt++;
    endtask

    task automatic test_wrap();
        // continues from test_fill: wp = 11, sample counter at 12
        for (int k = 0; k < 40; k++) begin
            step(1'b1, 4'd3);
            total++; if (c_wa !== 4'(11 + k) || c_ra !== 4'(8 + k)) $display("FAIL wrap_addr[%0d] wa=%0d ra=%0d want %0d %0d", k, c_wa, c_ra, 4'(11 + k), 4'(8 + k)); else pass_cnt++;
            total++; if (bus.delayed_valid !== 1'b1 || rdata !== 8'(9 + k)) $display("FAIL wrap_data[%0d] dv=%b data=%0d want 1 %0d", k, bus.delayed_valid, rdata, 9 + k); else pass_cnt++;
        end
    endtask

    task automatic test_full_depth();
        do_reset();
        step(1'b1, 4'd0);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 4'd0);
            total++; if (c_wr !== 1'b1 || c_rd !== 1'b0 || c_fill !== 1'b1) $display("FAIL full_fill[%0d] wr=%b rd=%b fill=%b want 1 0 1", i, c_wr, c_rd, c_fill); else pass_cnt++;
        end
        total++; if (bus.filling !== 1'b0) $display("FAIL full_exit got %b want 0", bus.filling); else pass_cnt++;
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 4'd0);
            total++; if (c_rd !== 1'b1 || c_wa !== 4'(k) || c_ra !== 4'(k)) $display("FAIL full_addr[%0d] rd=%b wa=%0d ra=%0d want 1 %0d %0d", k, c_rd, c_wa, c_ra, k, k); else pass_cnt++;
            total++; if (rdata !== 8'(k + 1)) $display("FAIL full_data[%0d] got %0d want %0d", k, rdata, k + 1); else pass_cnt++;
        end
    endtask

    task automatic test_offset_change();
        do_reset();
        repeat (7) step(1'b1, 4'd3);
        total++; if (c_rd !== 1'b1) $display("FAIL chg_pre_run rd got %b want 1", c_rd); else pass_cnt++;
        step(1'b1, 4'd5);
        total++; if (c_wr !== 1'b1 || c_rd !== 1'b0) $display("FAIL chg_strobe wr=%b rd=%b want 1 0", c_wr, c_rd); else pass_cnt++;
        total++; if (bus.filling !== 1'b1 || bus.delayed_valid !== 1'b0) $display("FAIL chg_refill fill=%b dv=%b want 1 0", bus.filling, bus.delayed_valid); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 4'd5);
            total++; if (c_rd !== 1'b0 || c_fill !== 1'b1 || bus.delayed_valid !== 1'b0) $display("FAIL chg_fill[%0d] rd=%b fill=%b dv=%b want 0 1 0", i, c_rd, c_fill, bus.delayed_valid); else pass_cnt++;
        end
        total++; if (bus.filling !== 1'b0) $display("FAIL chg_exit got %b want 0", bus.filling); else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 4'd5);
            total++; if (c_ra !== 4'(6 + k) || rdata !== 8'(7 + k)) $display("FAIL chg_run[%0d] ra=%0d data=%0d want %0d %0d", k, c_ra, rdata, 6 + k, 7 + k); else pass_cnt++;
        end
    endtask

    task automatic test_async_reset();
        bus.en = 1'b1;
        bus.offset = 4'd5;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (bus.wr !== 1'b0 || bus.rd !== 1'b0) $display("FAIL areset_strobes wr=%b rd=%b want 0 0", bus.wr, bus.rd); else pass_cnt++;
        total++; if (bus.wr_addr !== 4'd0 || bus.rd_addr !== 4'd0) $display("FAIL areset_addr wa=%0d ra=%0d want 0 0", bus.wr_addr, bus.rd_addr); else pass_cnt++;
        total++; if (bus.delayed_valid !== 1'b0 || bus.filling !== 1'b0) $display("FAIL areset_flags dv=%b fill=%b want 0 0", bus.delayed_valid, bus.filling); else pass_cnt++;
        bus.en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sample = 0;
        step(1'b1, 4'd3);
        total++; if (c_wr !== 1'b0) $display("FAIL areset_idle_wr got %b want 0", c_wr); else pass_cnt++;
        step(1'b1, 4'd3);
        total++; if (c_wr !== 1'b1 || c_wa !== 4'd0 || c_fill !== 1'b1) $display("FAIL areset_refill wr=%b wa=%0d fill=%b want 1 0 1", c_wr, c_wa, c_fill); else pass_cnt++;
    endtask

    initial begin
        bus.en = 1'b0;
        bus.offset = '0;
        din = '0;
        @(negedge clk);
        test_reset();
        test_fill();
        test_wrap();
        test_full_depth();
        test_offset_change();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/delay_ctrl.md
# delay_ctrl

- Address and strobe generator that drives the dual-port sample RAM as a circular delay line.
- On every input sample strobe it writes at a free-running write pointer.
- Once enough history has been stored, it reads back at the write pointer minus a programmable offset.
- Sits between the ADC/mic sample source and the RAM; the RAM's registered read data becomes the delayed audio output, qualified by this block's valid flag.

## Interface
- ADD_WIDTH, 9, RAM address width; buffer depth is 2**ADD_WIDTH samples
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  sample strobe; one new mic sample present this cycle
- offset  in  ADD_WIDTH  requested delay in samples; 0 means full depth (2**ADD_WIDTH)
- wr  out  1  RAM write enable
- rd  out  1  RAM read enable
- wr_addr  out  ADD_WIDTH  RAM write address
- rd_addr  out  ADD_WIDTH  RAM read address
- delayed_valid  out  1  RAM read data is a valid delayed sample this cycle
- filling  out  1  high while history is being accumulated (state FILL)

## Operation
- wr and rd are combinational from state and en. wr_addr and rd_addr are combinational from registers.
- Registers:
  - wp: write pointer, ADD_WIDTH bits
  - off_q: latched offset
  - fill_cnt: ADD_WIDTH+1 bits
  - state
  - delayed_valid flop
- Required fill count: need = (off_q == 0) ? 2**ADD_WIDTH : off_q, computed at ADD_WIDTH+1 bits.
- wr_addr = wp.
- rd_addr = (wp - off_q) mod 2**ADD_WIDTH. No saturation; wrap-around is intended.
- States:
  - IDLE: entered from reset.
    - wr = rd = 0.
    - On first en: latch off_q <= offset, go to FILL.
    - The first sample is not written in IDLE.
  - FILL: on en:
    - wr = 1, rd = 0, wp++, fill_cnt++.
    - When fill_cnt + 1 == need on that strobe, go to RUN.
  - RUN: on en:
    - wr = 1, rd = 1, wp++.
- Offset change: offset is compared to off_q on every en in FILL or RUN.
  - If they differ, that strobe is treated as a FILL write: wr = 1, rd = 0.
  - off_q <= offset, fill_cnt <= 1, state <= FILL.
  - If the new offset is 1, go straight to RUN instead.
  - Stale data is therefore never presented as delayed output.
- Simultaneous write and read at the same address (offset == 0 in RUN): the RAM returns old contents, which gives a delay of exactly 2**ADD_WIDTH samples.
- en low: all outputs hold except wr = rd = 0; no state change.
- Reset assertion mid-operation, all clear asynchronously:
  - wp, fill_cnt, off_q, state -> IDLE, delayed_valid.
  - RAM contents are not cleared; they are not trusted until refilled.

## Timing
- Reset values:
  - wr = 0, rd = 0, wr_addr = 0, rd_addr = 0
  - delayed_valid = 0, filling = 0
- Write latency: a sample presented with en in cycle N is written at wr_addr = wp in cycle N.
- Read latency:
  - rd asserted in cycle N; the RAM data is valid in cycle N+1.
  - delayed_valid is high in cycle N+1 only: registered copy of rd, one cycle wide per strobe.
- Delay: in RUN, the sample read on strobe k is the one written on strobe k - need.
- Back-to-back en on consecutive cycles is supported; no throughput limit.
- filling is high exactly while state == FILL.

## Structure
- Shared package delay_pkg:
  - typedef enum logic [1:0] {IDLE, FILL, RUN} delay_state_t
  - Default ADD_WIDTH constant, shared with the RAM top level.
- No sub-module. The RAM is instantiated beside this block in the top-level signal path, not inside it.

## Test plan
- Reset, then 3 idle cycles -> every output 0, filling 0.
- ADD_WIDTH = 4, offset = 3, en every cycle, samples 1, 2, 3, … via RAM model:
  - first en is absorbed by IDLE
  - wr on the next 3 strobes, filling high
  - rd starts on the 4th write strobe
  - delayed data sequence 1, 2, 3, … with delayed_valid one cycle after each rd
- Wrap-around with ADD_WIDTH = 4, offset = 3, run 40 strobes:
  - wr_addr wraps 15 -> 0
  - rd_addr = wr_addr - 3 mod 16, e.g. wr_addr 1 gives rd_addr 14
  - data stays continuous across the wrap
- offset = 0 with ADD_WIDTH = 4: 16 fill strobes, then rd_addr == wr_addr and output equals the sample from 16 strobes earlier.
- offset changes from 3 to 5 during RUN:
  - rd drops on that strobe, filling re-asserts
  - 4 more FILL strobes, then RUN
  - output delay becomes 5
  - no delayed_valid during refill
- rst_n asserted asynchronously mid-RUN, between clock edges:
  - all outputs go to 0 immediately
  - after release, the IDLE -> FILL sequence repeats from wp = 0
